// File: rtl/choreo_pkg.sv
// Shared pattern codes and speed encodings for the LED pattern generator
// and its upstream control stage.
package choreo_pkg;

  typedef logic [2:0] pat_t;

  localparam pat_t PAT_KNIGHT  = 3'd0;
  localparam pat_t PAT_BOUNCE  = 3'd1;
  localparam pat_t PAT_FILL    = 3'd2;
  localparam pat_t PAT_CHASE   = 3'd3;
  localparam pat_t PAT_BLINK   = 3'd4;
  localparam pat_t PAT_ALT     = 3'd5;
  localparam pat_t PAT_SPARKLE = 3'd6;
  localparam pat_t PAT_OFF     = 3'd7;

  // Last pattern visited by the unattended auto-cycle; PAT_OFF is skipped.
  localparam pat_t PAT_AUTO_LAST = 3'd6;

  localparam logic SPEED_FAST = 1'b0;
  localparam logic SPEED_SLOW = 1'b1;

  // Auto-advance successor: wraps to PAT_KNIGHT from PAT_AUTO_LAST and from PAT_OFF.
  function automatic pat_t auto_next(input pat_t p);
    return (p >= PAT_AUTO_LAST) ? PAT_KNIGHT : pat_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/pattern_control_if.sv
// Button/switch inputs and generator-facing controls of pattern_control.
interface pattern_control_if;
  import choreo_pkg::*;

  logic btn_next;
  logic btn_prev;
  logic btn_speed;
  logic btn_pause;
  logic auto_en;

  pat_t pat_sel;
  logic speed_sel;
  logic pause;
  logic ena;

  modport master (
    output btn_next, btn_prev, btn_speed, btn_pause, auto_en,
    input  pat_sel, speed_sel, pause, ena
  );

  modport slave (
    input  btn_next, btn_prev, btn_speed, btn_pause, auto_en,
    output pat_sel, speed_sel, pause, ena
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises one raw push-button, debounces it and emits a registered
// single-cycle pulse on each accepted press (release is silent).
module button_debouncer #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;

  // Count consecutive disagreeing samples; flip the accepted level on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser, debounce state and rising-edge press register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/pattern_control.sv
// Turns debounced button presses and the auto-cycle timer into the
// generator's pat_sel / speed_sel / pause controls plus a load strobe.
module pattern_control
  import choreo_pkg::*;
#(
  parameter int DB_CYCLES   = 3,
  parameter int AUTO_PERIOD = 64
) (
  input  logic clk,
  input  logic rst,
  pattern_control_if.slave bus
);

  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic press_next, press_prev, press_speed, press_pause;
  logic [3:0] unused_level;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_next),
    .level(unused_level[0]), .press(press_next)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_prev),
    .level(unused_level[1]), .press(press_prev)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_speed),
    .level(unused_level[2]), .press(press_speed)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_pause),
    .level(unused_level[3]), .press(press_pause)
  );

  logic          auto_sync1_q, auto_sync2_q;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  pat_t          pat_q, pat_d;
  logic          speed_q, speed_d;
  logic          pause_q, pause_d;
  logic          ena_q, ena_d;
  logic          load_pending_q;

  logic step_next, step_prev, auto_active, auto_fire;

  // Resolve press events and the auto timer into next output values.
  always_comb begin
    step_next   = press_next & ~press_prev;
    step_prev   = press_prev & ~press_next;
    auto_active = auto_sync2_q & ~pause_q;
    auto_fire   = auto_active && (auto_cnt_q == AUTO_LAST);

    pat_d      = pat_q;
    speed_d    = speed_q ^ press_speed;
    pause_d    = pause_q ^ press_pause;
    ena_d      = load_pending_q;
    auto_cnt_d = auto_cnt_q;

    if (!auto_sync2_q) begin
      auto_cnt_d = '0;
    end else if (auto_active) begin
      auto_cnt_d = auto_fire ? '0 : auto_cnt_q + AW'(1);
    end

    // Manual steps win over a coincident auto-advance and restart the period.
    if (step_next) begin
      pat_d      = pat_t'(pat_q + 3'd1);
      ena_d      = 1'b1;
      auto_cnt_d = '0;
    end else if (step_prev) begin
      pat_d      = pat_t'(pat_q - 3'd1);
      ena_d      = 1'b1;
      auto_cnt_d = '0;
    end else if (auto_fire) begin
      pat_d = auto_next(pat_q);
      ena_d = 1'b1;
    end
  end

  // Output, timer and auto_en synchroniser registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_sync1_q   <= 1'b0;
      auto_sync2_q   <= 1'b0;
      auto_cnt_q     <= '0;
      pat_q          <= PAT_KNIGHT;
      speed_q        <= SPEED_FAST;
      pause_q        <= 1'b0;
      ena_q          <= 1'b0;
      load_pending_q <= 1'b1;
    end else begin
      auto_sync1_q   <= bus.auto_en;
      auto_sync2_q   <= auto_sync1_q;
      auto_cnt_q     <= auto_cnt_d;
      pat_q          <= pat_d;
      speed_q        <= speed_d;
      pause_q        <= pause_d;
      ena_q          <= ena_d;
      load_pending_q <= 1'b0;
    end
  end

  assign bus.pat_sel   = pat_q;
  assign bus.speed_sel = speed_q;
  assign bus.pause     = pause_q;
  assign bus.ena       = ena_q;

endmodule

// File: tb/tb_pattern_control.sv
// Directed bench for pattern_control with DB_CYCLES=3, AUTO_PERIOD=4.
module tb_pattern_control;
  import choreo_pkg::*;

  localparam int DB = 3;
  localparam int AP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pattern_control_if bus ();

  pattern_control #(.DB_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ena_cnt  = 0;
  int base;

  // Count every cycle that carries an ena pulse.
  always @(negedge clk) if (bus.ena === 1'b1) ena_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_next  = v;
      1: bus.btn_prev  = v;
      2: bus.btn_speed = v;
      default: bus.btn_pause = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(8);
    set_btn(which, 1'b0);
    tick(8);
  endtask

  initial begin
    bus.btn_next = 0; bus.btn_prev = 0; bus.btn_speed = 0;
    bus.btn_pause = 0; bus.auto_en = 0;

    // Reset state and post-reset load pulse
    tick(3);
    check("rst_pat", bus.pat_sel, 0);
    check("rst_ena", bus.ena, 0);
    check("rst_speed", bus.speed_sel, 0);
    check("rst_pause", bus.pause, 0);
    rst = 1'b0;
    tick(1);
    check("load_ena", bus.ena, 1);
    check("load_pat", bus.pat_sel, 0);
    tick(1);
    check("load_ena_off", bus.ena, 0);

    // Debounce latency: outputs move DB+3 edges after the first high sample
    base = ena_cnt;
    bus.btn_next = 1;
    tick(6);
    check("lat_pat_early", bus.pat_sel, 0);
    check("lat_ena_early", bus.ena, 0);
    tick(1);
    check("lat_pat", bus.pat_sel, 1);
    check("lat_ena", bus.ena, 1);
    tick(1);
    check("lat_ena_single", bus.ena, 0);
    bus.btn_next = 0;
    tick(8);
    check("lat_ena_count", ena_cnt - base, 1);

    // Bounce rejection then one clean press
    base = ena_cnt;
    repeat (4) begin
      bus.btn_next = 1; tick(2);
      bus.btn_next = 0; tick(2);
    end
    tick(8);
    check("bounce_pat", bus.pat_sel, 1);
    check("bounce_ena", ena_cnt - base, 0);
    press(0);
    check("clean_pat", bus.pat_sel, 2);
    check("clean_ena", ena_cnt - base, 1);

    // Prev wrap 0 -> 7
    press(1);
    press(1);
    check("prev_to0", bus.pat_sel, 0);
    press(1);
    check("prev_wrap", bus.pat_sel, 7);

    // Simultaneous next+prev cancels
    base = ena_cnt;
    bus.btn_next = 1; bus.btn_prev = 1;
    tick(8);
    bus.btn_next = 0; bus.btn_prev = 0;
    tick(8);
    check("cancel_pat", bus.pat_sel, 7);
    check("cancel_ena", ena_cnt - base, 0);
    press(0);
    check("next_wrap", bus.pat_sel, 0);

    // Speed toggle does not strobe ena
    base = ena_cnt;
    press(2);
    check("speed_sel", bus.speed_sel, 1);
    check("speed_no_ena", ena_cnt - base, 0);
    check("speed_pat", bus.pat_sel, 0);

    // Auto-cycle from 5: 5,6,0,1 every 4 cycles
    repeat (5) press(0);
    check("auto_start", bus.pat_sel, 5);
    base = ena_cnt;
    bus.auto_en = 1;
    tick(5);
    check("auto_hold5", bus.pat_sel, 5);
    tick(1);
    check("auto_6", bus.pat_sel, 6);
    check("auto_ena", bus.ena, 1);
    tick(4);
    check("auto_skip7_0", bus.pat_sel, 0);
    tick(4);
    check("auto_1", bus.pat_sel, 1);

    // Pause press lands after one more advance (to 2) and freezes the count at 3
    press(3);
    check("pause_on", bus.pause, 1);
    check("pause_pat", bus.pat_sel, 2);
    check("auto_ena_count", ena_cnt - base, 4);
    tick(10);
    check("pause_frozen", bus.pat_sel, 2);

    // Resume: preserved count fires on the first active cycle
    bus.btn_pause = 1;
    tick(7);
    check("resume_pause", bus.pause, 0);
    check("resume_hold", bus.pat_sel, 2);
    tick(1);
    check("resume_adv", bus.pat_sel, 3);
    check("resume_ena", bus.ena, 1);
    bus.btn_pause = 0;
    tick(5);

    // Manual next coinciding with an auto-advance: single step, period restarts
    bus.btn_next = 1;
    tick(6);
    check("prio_before", bus.pat_sel, 5);
    tick(1);
    check("prio_single", bus.pat_sel, 6);
    check("prio_ena", bus.ena, 1);
    bus.btn_next = 0;
    tick(3);
    check("prio_restart", bus.pat_sel, 6);
    tick(1);
    check("prio_next_auto", bus.pat_sel, 0);
    bus.auto_en = 0;
    tick(4);
    check("auto_off_pat", bus.pat_sel, 0);

    // Reset during a speed debounce discards the pending press
    bus.btn_speed = 1;
    tick(4);
    rst = 1'b1;
    bus.btn_speed = 0;
    tick(2);
    check("mrst_speed", bus.speed_sel, 0);
    check("mrst_pat", bus.pat_sel, 0);
    check("mrst_ena", bus.ena, 0);
    base = ena_cnt;
    rst = 1'b0;
    tick(1);
    check("mrst_load", bus.ena, 1);
    tick(10);
    check("mrst_no_stale", bus.speed_sel, 0);
    check("mrst_pause", bus.pause, 0);
    check("mrst_ena_count", ena_cnt - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
